add_req_arbiter: RTL

- Round-robin scheduler that shares one 16+16 -> 32-bit adder core among NUM_REQ requesters.
- Each requester posts an operand pair; the arbiter grants one requester, launches the core with a start pulse and waits for done.
- It returns the sum to the granted requester only, and provides a watchdog for a core that never completes.
- Sits between requester-side masters and the adder core, in place of direct per-master control of start.

---
 rtl/add_req_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/add_req_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// add_req_arbiter : round-robin sharing of one 16+16->32 adder core among
//                   NUM_REQ requesters, with a completion watchdog.
// Revision        : 1.0
// ---------------------------------------------------------------------------
module add_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rsp_vld,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  core_start,
  output logic [15:0]           core_a,
  output logic [15:0]           core_b,
  input  logic [31:0]           core_s,
  input  logic                  core_done,
  input  logic                  core_busy,
  output logic                  arb_busy
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CW   = IDXW + 1;
  localparam logic [15:0]        CNT_LAST = 16'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [IDXW-1:0] last_idx;
  logic [IDXW-1:0] gnt_idx;
  logic [IDXW-1:0] sel_idx;
  logic            sel_found;
  logic [CW-1:0]   cand;
  logic [15:0]     wd_cnt;
  logic            launch;
  logic            finish_ok;
  logic            finish_to;

  // Search starts just after the last served requester and wraps around.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_idx} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!sel_found && req[cand[IDXW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDXW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    finish_ok  = 1'b0;
    finish_to  = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found && !core_busy) begin
          launch     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        // A completion in the last watchdog cycle still counts as success.
        if (core_done) begin
          finish_ok  = 1'b1;
          state_next = RESP;
        end else if (wd_cnt == CNT_LAST) begin
          finish_to  = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign core_start = (state == ISSUE);
  assign arb_busy   = (state != IDLE);
  assign rsp_vld    = (state == RESP) ? gnt : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt      <= '0;
      gnt_idx  <= '0;
      last_idx <= IDXW'(NUM_REQ - 1);
      core_a   <= '0;
      core_b   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      wd_cnt   <= '0;
    end else begin
      if (launch) begin
        gnt     <= ONE << sel_idx;
        gnt_idx <= sel_idx;
        core_a  <= req_a[{sel_idx, 4'b0000} +: 16];
        core_b  <= req_b[{sel_idx, 4'b0000} +: 16];
      end

      if (state == ISSUE)     wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 16'd1;

      if (finish_ok) begin
        rsp_data <= core_s;
        rsp_err  <= 1'b0;
      end else if (finish_to) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end

      if (state == RESP) begin
        gnt      <= '0;
        last_idx <= gnt_idx;
        rsp_data <= '0;
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
